// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, parity-check rows, encoder and FSM states.
// HAMMING_TX_GAP_EN adds the one-cycle GAP state between codewords.
package hamming_pkg;

   localparam int DATA_W = 4;
   localparam int CW_W   = 8;

   localparam logic [CW_W-1:0] H_ROW0 = 8'b00111010;
   localparam logic [CW_W-1:0] H_ROW1 = 8'b01001110;
   localparam logic [CW_W-1:0] H_ROW2 = 8'b10011100;

`ifdef HAMMING_TX_GAP_EN
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } tx_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT
   } tx_state_t;
`endif

   function automatic logic [CW_W-1:0] hamming_encode(
      input logic [DATA_W-1:0] d
   );
      logic [CW_W-1:0] c;
      c    = '0;
      c[1] = d[3];
      c[2] = d[2];
      c[3] = d[1];
      c[4] = d[0];
      c[5] = c[4] ^ c[3] ^ c[1];
      c[6] = c[3] ^ c[2] ^ c[1];
      c[7] = c[4] ^ c[3] ^ c[2];
      c[0] = ^c[7:1];
      return c;
   endfunction

endpackage

// File: rtl/hamming_tx_serializer_fifo.sv
// nibble_fifo: synchronous FIFO with push, pop, full, empty and count.
// DEPTH must be a power of two so the pointers wrap for free.
module nibble_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next pointers and occupancy; push+pop together leaves count alone
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; empty FIFO contents are never read
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/hamming_tx_serializer.sv
// hamming_tx_serializer: buffers nibbles, encodes them and shifts each
// codeword out LSB first. HAMMING_TX_GAP_EN inserts one idle bit between words.
module hamming_tx_serializer
   import hamming_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0]                    in_data,
   output logic                          out_bit,
   output logic                          out_en,
   output logic                          out_sof,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   tx_state_t          state_q, state_d;
   logic [CW_W-1:0]    sr_q, sr_d;
   logic [2:0]         bitcnt_q, bitcnt_d;
   logic               push, pop, full, empty;
   logic [DATA_W-1:0]  fifo_dout;

   assign in_ready = !full;
   assign push     = in_valid && in_ready;

   nibble_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (in_data),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

   // Next state, shift register load/shift and serial outputs
   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      bitcnt_d = bitcnt_q;
      pop      = 1'b0;
      out_bit  = 1'b0;
      out_en   = 1'b0;
      out_sof  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               sr_d     = hamming_encode(fifo_dout);
               bitcnt_d = '0;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            out_bit  = sr_q[0];
            out_en   = 1'b1;
            out_sof  = (bitcnt_q == 3'd0);
            sr_d     = {1'b0, sr_q[CW_W-1:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
`ifdef HAMMING_TX_GAP_EN
               state_d = ST_GAP;
`else
               if (!empty) begin
                  pop      = 1'b1;
                  sr_d     = hamming_encode(fifo_dout);
                  bitcnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
`endif
            end
         end
`ifdef HAMMING_TX_GAP_EN
         ST_GAP: begin
            if (!empty) begin
               pop      = 1'b1;
               sr_d     = hamming_encode(fifo_dout);
               bitcnt_d = '0;
               state_d  = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State, shift register and bit counter; reset aborts any codeword
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sr_q     <= '0;
         bitcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
      end
   end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// tb_hamming_tx_serializer: random and directed nibbles, scoreboard queue
// of expected codewords, independent serial monitor with parity checks.
module tb_hamming_tx_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;
   logic       in_ready;
   logic       out_bit, out_en, out_sof;
   logic [2:0] fifo_count;

   localparam logic [7:0] H0 = 8'b00111010;
   localparam logic [7:0] H1 = 8'b01001110;
   localparam logic [7:0] H2 = 8'b10011100;
`ifdef HAMMING_TX_GAP_EN
   localparam int PERIOD = 9;
`else
   localparam int PERIOD = 8;
`endif

   always #5 clk = ~clk;

   hamming_tx_serializer #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_bit    (out_bit),
      .out_en     (out_en),
      .out_sof    (out_sof),
      .fifo_count (fifo_count)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int sof_t[$];
   int idx = 0;
   int ncw = 0;
   logic [7:0] cw = 8'd0;
   logic [7:0] last_cw = 8'd0;
   bit saw_full = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: the unique byte whose data positions hold d and which
   // satisfies all three check rows plus overall even parity.
   function automatic logic [7:0] ref_encode(input logic [3:0] d);
      logic [7:0] v;
      for (int c = 0; c < 256; c++) begin
         v = 8'(c);
         if (v[1] == d[3] && v[2] == d[2] && v[3] == d[1] && v[4] == d[0]
             && ^(v & H0) == 1'b0 && ^(v & H1) == 1'b0
             && ^(v & H2) == 1'b0 && ^v == 1'b0)
            return v;
      end
      return 8'hxx;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic send(input logic [3:0] nib, input bit keep);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = nib;
      while (!in_ready && t < 100) begin
         saw_full = 1;
         chk("ready_low_count", 32'(fifo_count), 32'd4);
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         chk("push_timeout", 32'(t), 32'd0);
      end else begin
         exp_q.push_back(ref_encode(nib));
         @(negedge clk);
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || idx != 0 || out_en) && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: assemble serial bits into codewords and score them
   always @(negedge clk) begin
      if (reset) begin
         idx = 0;
      end else begin
         if (out_sof && !out_en) begin
            errors++; checks++;
            $display("FAIL sof_without_en at cycle %0d", cyc);
         end
         if (!out_en && out_bit) begin
            errors++; checks++;
            $display("FAIL bit_without_en at cycle %0d", cyc);
         end
         if (out_en) begin
            if (out_sof) begin
               if (idx != 0) begin
                  errors++; checks++;
                  $display("FAIL sof_mid_word: idx %0d expected 0", idx);
               end
               idx = 0;
               sof_t.push_back(cyc);
            end else if (idx == 0) begin
               errors++; checks++;
               $display("FAIL missing_sof at cycle %0d", cyc);
            end
            cw[idx] = out_bit;
            idx++;
            if (idx == 8) begin
               idx = 0;
               ncw++;
               last_cw = cw;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none", cw);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  if (cw !== e) begin
                     errors++;
                     $display("FAIL codeword: got %0h expected %0h", cw, e);
                  end
               end
               checks++;
               if ((^(cw & H0)) || (^(cw & H1)) || (^(cw & H2)) || (^cw)) begin
                  errors++;
                  $display("FAIL parity: got %0h expected zero syndrome", cw);
               end
            end
         end else if (idx != 0) begin
            errors++; checks++;
            $display("FAIL en_drop_mid_word: idx %0d expected 0", idx);
            idx = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, ncw0, t, en_cnt;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_en", 32'(out_en), 32'd0);
      chk("rst_out_sof", 32'(out_sof), 32'd0);
      chk("rst_out_bit", 32'(out_bit), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);

      // Single nibble: latency and 0x3A serialisation
      send(4'b1011, 0);
      chk("t1_en_before_load", 32'(out_en), 32'd0);
      chk("t1_count_after_push", 32'(fifo_count), 32'd1);
      @(negedge clk);
      chk("t1_sof_latency", 32'(out_sof), 32'd1);
      chk("t1_en_latency", 32'(out_en), 32'd1);
      drain();
      chk("t1_word", 32'(last_cw), 32'h3A);

      // Three back-to-back words: spacing between sofs
      base = sof_t.size();
      ncw0 = ncw;
      send(4'b0000, 1);
      send(4'b1111, 1);
      send(4'b0001, 0);
      drain();
      chk("t2_words", 32'(ncw - ncw0), 32'd3);
      chk("t2_last_word", 32'(last_cw), 32'hB1);
      for (int i = base + 1; i < sof_t.size(); i++)
         chk("t2_period", 32'(sof_t[i] - sof_t[i-1]), 32'(PERIOD));

      // Continuous valid: FIFO fills, order preserved by scoreboard
      saw_full = 0;
      ncw0 = ncw;
      for (int i = 0; i < 12; i++)
         send(4'($urandom_range(0, 15)), i < 11);
      drain();
      chk("t3_full_seen", 32'(saw_full), 32'd1);
      chk("t3_words", 32'(ncw - ncw0), 32'd12);

      // Reset at bit 3 with two nibbles queued
      base = sof_t.size();
      send(4'($urandom_range(0, 15)), 1);
      send(4'($urandom_range(0, 15)), 1);
      send(4'($urandom_range(0, 15)), 0);
      t = 0;
      while (!(out_en && sof_t.size() > base
               && cyc - sof_t[sof_t.size()-1] == 3) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("t4_reach_bit3", 32'(t < 50), 32'd1);
      chk("t4_queued", 32'(fifo_count), 32'd2);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("t4_out_en", 32'(out_en), 32'd0);
      chk("t4_out_sof", 32'(out_sof), 32'd0);
      chk("t4_out_bit", 32'(out_bit), 32'd0);
      chk("t4_fifo_count", 32'(fifo_count), 32'd0);
      chk("t4_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      en_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_en) en_cnt++;
      end
      chk("t4_silent", 32'(en_cnt), 32'd0);

      // All sixteen nibbles
      ncw0 = ncw;
      for (int n = 0; n < 16; n++)
         send(4'(n), n < 15);
      drain();
      chk("t5_words", 32'(ncw - ncw0), 32'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hamming_tx_serializer.md
# hamming_tx_serializer

- Transmit-side neighbour of the serial Hamming decoder. It accepts 4-bit data nibbles over a valid/ready handshake and buffers them in a small FIFO.
- Each nibble is encoded into an 8-bit codeword whose syndrome is zero under the team's parity-check matrix.
- The codeword is shifted out one bit per cycle, bit 0 first, with a bit-enable strobe that drives the decoder's `en` input.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: nibble FIFO depth; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` holds a nibble to send.
- `in_ready` out 1: block can accept a nibble.
- `in_data` in 4: data nibble `d[3:0]`.
- `out_bit` out 1: serial codeword bit.
- `out_en` out 1: `out_bit` valid this cycle.
- `out_sof` out 1: high with bit 0 of each codeword.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: nibbles currently buffered.

## Operation
- Accept: a nibble is accepted on an edge where `in_valid && in_ready`.
  - `in_ready = (fifo_count != FIFO_DEPTH)`, a purely registered condition.
  - There is no pass-through when full.
- Encode: codeword `c[7:0]` is built as follows.
  - Data bits: `c1=d3`, `c2=d2`, `c3=d1`, `c4=d0`.
  - `c5 = c4^c3^c1`.
  - `c6 = c3^c2^c1`.
  - `c7 = c4^c3^c2`.
  - `c0` = XOR of `c[7:1]`, giving even overall parity.
  - Check rows: H0=8'b00111010, H1=8'b01001110, H2=8'b10011100. `c & Hi` has even weight for every i.
- FSM states:
  - `IDLE`: FIFO empty, `out_en=0`. Moves to `SHIFT` on the edge where the FIFO is non-empty; that edge pops the FIFO into the 8-bit shift register and clears the bit counter.
  - `SHIFT`: `out_bit = sr[0]`, `out_en=1`, `out_sof = (bitcnt==0)`.
    - Each edge shifts right and increments `bitcnt`.
    - At `bitcnt==7`, if the FIFO is non-empty, pop and load the next codeword and stay in `SHIFT`; otherwise go to `IDLE`.
  - `GAP`: exists only with the macro below.
- Simultaneous push and pop of the FIFO in one cycle is legal; `fifo_count` is then unchanged.
- Push when full is impossible because `in_ready=0`. Pop occurs only when non-empty.
- FIFO pointers wrap modulo `FIFO_DEPTH`; the count saturates logic at 0 and `FIFO_DEPTH`.
- Reset, including mid-codeword:
  - Abort the current codeword immediately and empty the FIFO.
  - State becomes `IDLE`.
  - Outputs after reset: `out_bit=0`, `out_en=0`, `out_sof=0`, `in_ready=1`, `fifo_count=0`.
  - Partially sent bits are not resumed.

## Timing
- All outputs are registered or derived from registers. There is no combinational path from `in_valid`/`in_data` to any output.
- Latency, empty FIFO and `IDLE`:
  - Nibble accepted at edge N.
  - Loaded at edge N+1.
  - `out_en` and `out_sof` high in the cycle after N+1.
  - Bit 7 is presented 7 cycles later.
- Back-to-back codewords are gapless by default, giving 8 bits per 8 cycles. Sustained throughput is one nibble per 8 cycles.
- `out_sof` pulses exactly once per codeword and always coincides with `out_en`.

## Configuration
- `HAMMING_TX_GAP_EN`:
  - Defined: after bit 7 the FSM always enters `GAP` for exactly one cycle (`out_en=0`, `out_bit=0`). It then loads from the FIFO if non-empty, otherwise goes to `IDLE`. Codeword period becomes 9 cycles, giving the downstream decoder a re-arm cycle.
  - Undefined: the `GAP` state and its logic are absent, and streaming is gapless.

## Structure
- Shared package `hamming_pkg`:
  - `DATA_W=4`, `CW_W=8`.
  - `H_ROW0/1/2` constants.
  - `hamming_encode(d)` function returning `c[7:0]`.
  - FSM state typedef `tx_state_t`.
- Sub-module `nibble_fifo`: parameterised synchronous FIFO with push, pop, full, empty and count.
- Top level contains the FSM, encoder call and shift register.

## Test plan
- After reset, check `in_ready=1`, `out_en=0`, `fifo_count=0`. Then push 4'b1011 and check 0x3A is serialised LSB first: 0,1,0,1,1,1,0,0, with `out_sof` on the first bit only.
- Push 4'b0000, 4'b1111 and 4'b0001 back to back. Check gapless codewords 0x00, 0xFF, 0xB1 over 24 consecutive `out_en` cycles.
- Hold `in_valid=1` continuously. Check `in_ready` drops when `fifo_count=4`, no nibble is lost or duplicated, and order is preserved.
- Assert `reset` at bit 3 of a codeword with 2 nibbles queued. Check the next cycle has `out_en=0` and `fifo_count=0`, and that nothing is emitted afterwards without new input.
- Encode all 16 nibbles and check every output codeword against the three H rows (even parity each) plus overall even parity.
- With `HAMMING_TX_GAP_EN` defined, send two nibbles and check exactly one `out_en=0` cycle between the codewords (period 9).
